bp_be_rpt_pf_sched: RTL and testbench

Prefetch scheduler that turns stride-valid reports from the backend reference prediction table into line-aligned D$ prefetch requests. It queues stride candidates and expands each one into `pf_degree_p` sequential line prefetches. It yields the D$ port to demand traffic and drops redundant or same-line requests. It sits between the RPT outputs and the D$ prefetch request port, alongside the load pipe.

---
 rtl/bp_be_rpt_pf_sched_pkg.sv | 28 ++
 rtl/bp_be_rpt_pf_sched_if.sv | 10 +
 rtl/bp_be_rpt_pf_sched_fifo.sv | 45 ++++
 rtl/bp_be_rpt_pf_sched.sv | 151 +++++++++++++++
 tb/tb_bp_be_rpt_pf_sched.sv | 256 +++++++++++++++++++++++++
 5 files changed

// File: rtl/bp_be_rpt_pf_sched_pkg.sv
// Shared types for the RPT prefetch scheduler: FSM state encoding, the
// candidate-queue entry declare macro and a saturating-increment helper.
package bp_be_rpt_pf_sched_pkg;

  typedef enum logic [1:0] {
    e_idle  = 2'd0,
    e_load  = 2'd1,
    e_offer = 2'd2
  } bp_be_rpt_pf_state_e;

  // Event counters stick at all-ones instead of wrapping
  function automatic logic [31:0] bp_be_rpt_pf_sat_inc(input logic [31:0] v);
    return (&v) ? v : (v + 32'd1);
  endfunction

endpackage

`ifndef BP_BE_RPT_PF_ENTRY_DECLARE
`define BP_BE_RPT_PF_ENTRY_DECLARE
// One stride candidate: first address to prefetch, the stride to step by,
// and how many line prefetches remain for it.
`define BP_BE_RPT_PF_ENTRY_DECL(vaddr_w, stride_w, cnt_w) \
  typedef struct packed {                                      \
    logic [vaddr_w-1:0]  next_addr;                            \
    logic [stride_w-1:0] stride;                               \
    logic [cnt_w-1:0]    cnt;                                  \
  } bp_be_rpt_pf_entry_s;
`endif

// File: rtl/bp_be_rpt_pf_sched_if.sv
// Prefetch request channel from the scheduler (master) to the D$ (slave).
// pf_yumi may only be raised while pf_v is high.
interface bp_be_rpt_pf_sched_if #(parameter int vaddr_width_p = 39) ();
  logic                     pf_v;
  logic [vaddr_width_p-1:0] pf_addr;
  logic                     pf_yumi;

  modport master (output pf_v, output pf_addr, input pf_yumi);
  modport slave  (input pf_v, input pf_addr, output pf_yumi);
endinterface

// File: rtl/bp_be_rpt_pf_sched_fifo.sv
// Small candidate FIFO with the bsg_fifo_1r1w_small handshake: v_i pushes,
// yumi_i pops the head shown on data_o. A pop and a push in the same cycle
// are allowed while full because the head is read before the slot is reused.
module bp_be_rpt_pf_sched_fifo #(
  parameter int width_p = 8,
  parameter int els_p   = 4
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               clear_i,
  input  logic               v_i,
  input  logic [width_p-1:0] data_i,
  input  logic               yumi_i,
  output logic               v_o,
  output logic               full_o,
  output logic [width_p-1:0] data_o
);
  localparam int ptr_w_lp = $clog2(els_p);

  logic [width_p-1:0]  mem_q [els_p];
  logic [ptr_w_lp-1:0] rptr_q, wptr_q;
  logic [ptr_w_lp:0]   count_q;

  // Pointer and occupancy tracking; clear empties the queue in one cycle
  always_ff @(posedge clk_i) begin
    if (reset_i | clear_i) begin
      rptr_q  <= '0;
      wptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (v_i)    wptr_q <= wptr_q + 1'b1;
      if (yumi_i) rptr_q <= rptr_q + 1'b1;
      count_q <= count_q + (ptr_w_lp+1)'(v_i) - (ptr_w_lp+1)'(yumi_i);
    end
  end

  // Storage write; contents need no reset since occupancy gates the reads
  always_ff @(posedge clk_i) begin
    if (v_i) mem_q[wptr_q] <= data_i;
  end

  assign v_o    = (count_q != '0);
  assign full_o = (count_q == (ptr_w_lp+1)'(els_p));
  assign data_o = mem_q[rptr_q];
endmodule

// File: rtl/bp_be_rpt_pf_sched.sv
// RPT prefetch scheduler: queues stride candidates from the RPT and expands
// each into pf_degree_p line-aligned prefetches toward the D$, yielding to
// demand traffic and skipping requests for the line just prefetched.
// Optional build macro BP_BE_RPT_PF_STATS_EN adds stats_o event counters.
module bp_be_rpt_pf_sched
  import bp_be_rpt_pf_sched_pkg::*;
#(
  parameter int vaddr_width_p  = 39,
  parameter int stride_width_p = 8,
  parameter int block_width_p  = 512,
  parameter int pf_queue_els_p = 4,
  parameter int pf_degree_p    = 2
) (
  input  logic                      clk_i,
  input  logic                      reset_i,
  input  logic                      init_done_i,
  input  logic                      train_v_i,
  input  logic [vaddr_width_p-1:0]  train_pc_i,
  input  logic [vaddr_width_p-1:0]  train_addr_i,
  input  logic [stride_width_p-1:0] train_stride_i,
  input  logic                      flush_i,
  input  logic                      demand_v_i,
  bp_be_rpt_pf_sched_if.master      pf_if,
  output logic                      busy_o
`ifdef BP_BE_RPT_PF_STATS_EN
  ,output logic [95:0]              stats_o
`endif
);
  localparam int offset_lp    = $clog2(block_width_p/8);
  localparam int cnt_width_lp = $clog2(pf_degree_p+1);

  `BP_BE_RPT_PF_ENTRY_DECL(vaddr_width_p, stride_width_p, cnt_width_lp)

  bp_be_rpt_pf_state_e       state_q, state_d;
  bp_be_rpt_pf_entry_s       push_entry, head_entry;
  logic [vaddr_width_p-1:0]  cur_addr_q, cur_addr_d, last_line_q, last_line_d;
  logic [vaddr_width_p-1:0]  last_pc_q, last_pc_d;
  logic [stride_width_p-1:0] stride_q, stride_d;
  logic [cnt_width_lp-1:0]   cnt_q, cnt_d;
  logic [vaddr_width_p-1:0]  train_stride_sext, work_stride_sext, cur_line;
  logic fifo_v, fifo_full, fifo_push, fifo_pop;
  logic train_fire, train_drop, same_line, offer_st, pf_v, issue, skip, advance;

  assign train_stride_sext = {{(vaddr_width_p-stride_width_p){train_stride_i[stride_width_p-1]}}, train_stride_i};
  assign work_stride_sext  = {{(vaddr_width_p-stride_width_p){stride_q[stride_width_p-1]}}, stride_q};
  assign cur_line          = {cur_addr_q[vaddr_width_p-1:offset_lp], {offset_lp{1'b0}}};

  // Training filter: zero stride, no room (after this cycle's pop) or a
  // repeat of the last accepted PC while work is still queued is dropped
  always_comb begin
    train_fire = train_v_i & init_done_i & ~flush_i;
    train_drop = train_fire & ((train_stride_i == '0)
                             | (fifo_full & ~fifo_pop)
                             | (fifo_v & (train_pc_i == last_pc_q)));
    fifo_push  = train_fire & ~train_drop;
    push_entry.next_addr = train_addr_i + train_stride_sext;
    push_entry.stride    = train_stride_i;
    push_entry.cnt       = cnt_width_lp'(pf_degree_p);
  end

  bp_be_rpt_pf_sched_fifo #(
    .width_p ($bits(bp_be_rpt_pf_entry_s)),
    .els_p   (pf_queue_els_p)
  ) cand_fifo (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .clear_i (flush_i),
    .v_i     (fifo_push),
    .data_i  (push_entry),
    .yumi_i  (fifo_pop),
    .v_o     (fifo_v),
    .full_o  (fifo_full),
    .data_o  (head_entry)
  );

  // Next-state and offer logic; demand traffic freezes the work register
  always_comb begin
    state_d     = state_q;
    cur_addr_d  = cur_addr_q;
    stride_d    = stride_q;
    cnt_d       = cnt_q;
    last_line_d = last_line_q;
    offer_st    = (state_q == e_offer);
    same_line   = (cur_line == last_line_q);
    pf_v        = offer_st & ~same_line & ~demand_v_i & ~reset_i;
    issue       = pf_v & pf_if.pf_yumi;
    skip        = offer_st & ~demand_v_i & same_line;
    advance     = issue | skip;
    fifo_pop    = (state_q == e_load);
    case (state_q)
      e_idle: if (fifo_v) state_d = e_load;
      e_load: begin
        cur_addr_d = head_entry.next_addr;
        stride_d   = head_entry.stride;
        cnt_d      = head_entry.cnt;
        state_d    = e_offer;
      end
      e_offer: if (advance) begin
        cur_addr_d = cur_addr_q + work_stride_sext;
        cnt_d      = cnt_q - cnt_width_lp'(1);
        if (issue) last_line_d = cur_line;
        if (cnt_q == cnt_width_lp'(1)) state_d = fifo_v ? e_load : e_idle;
      end
      default: state_d = e_idle;
    endcase
    if (flush_i) state_d = e_idle;
    last_pc_d = flush_i ? '0 : (fifo_push ? train_pc_i : last_pc_q);
  end

  // State and work register update
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q     <= e_idle;
      cur_addr_q  <= '0;
      stride_q    <= '0;
      cnt_q       <= '0;
      last_line_q <= '0;
      last_pc_q   <= '0;
    end else begin
      state_q     <= state_d;
      cur_addr_q  <= cur_addr_d;
      stride_q    <= stride_d;
      cnt_q       <= cnt_d;
      last_line_q <= last_line_d;
      last_pc_q   <= last_pc_d;
    end
  end

  assign pf_if.pf_v    = pf_v;
  assign pf_if.pf_addr = offer_st ? cur_line : '0;
  assign busy_o        = (state_q != e_idle) | fifo_v;

`ifdef BP_BE_RPT_PF_STATS_EN
  logic [31:0] issued_q, dropped_q, skipped_q;

  // Saturating event counters; survive flush, cleared only by reset
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      issued_q  <= '0;
      dropped_q <= '0;
      skipped_q <= '0;
    end else begin
      if (issue)      issued_q  <= bp_be_rpt_pf_sat_inc(issued_q);
      if (train_drop) dropped_q <= bp_be_rpt_pf_sat_inc(dropped_q);
      if (skip)       skipped_q <= bp_be_rpt_pf_sat_inc(skipped_q);
    end
  end

  assign stats_o = {skipped_q, dropped_q, issued_q};
`endif
endmodule

// File: tb/tb_bp_be_rpt_pf_sched.sv
// Self-checking bench for bp_be_rpt_pf_sched: directed scenarios with
// literal expectations, then randomized traffic against a queue-based model.
module tb_bp_be_rpt_pf_sched;
  localparam longint MASK = 64'h7F_FFFF_FFFF;
  localparam int     QD   = 4;
  localparam int     DEG  = 2;

  logic        clk = 1'b0;
  logic        reset_i, init_done_i, train_v_i, flush_i, demand_v_i, busy_o;
  logic [38:0] train_pc_i, train_addr_i;
  logic [7:0]  train_stride_i;
`ifdef BP_BE_RPT_PF_STATS_EN
  logic [95:0] stats_o;
`endif

  always #5 clk = ~clk;

  bp_be_rpt_pf_sched_if #(.vaddr_width_p(39)) pf_if ();

  bp_be_rpt_pf_sched #(
    .vaddr_width_p(39), .stride_width_p(8), .block_width_p(512),
    .pf_queue_els_p(QD), .pf_degree_p(DEG)
  ) dut (
    .clk_i(clk), .reset_i(reset_i), .init_done_i(init_done_i),
    .train_v_i(train_v_i), .train_pc_i(train_pc_i), .train_addr_i(train_addr_i),
    .train_stride_i(train_stride_i), .flush_i(flush_i), .demand_v_i(demand_v_i),
    .pf_if(pf_if), .busy_o(busy_o)
`ifdef BP_BE_RPT_PF_STATS_EN
    ,.stats_o(stats_o)
`endif
  );

  // ---------------- behavioural model ----------------
  typedef struct { longint addr; longint stride; } cand_t;
  cand_t  m_q[$];
  int     m_phase;          // 0: nothing in hand, 1: taking head, 2: working a candidate
  longint m_cur, m_stride, m_last_line, m_last_pc;
  int     m_left;
  int     m_issued, m_dropped, m_skipped;

  int     n_checks = 0, n_errors = 0;
  longint got[$];
  bit     g_cmp, g_yumi, g_demand, g_init;

  function automatic longint line_of(longint a);
    return a & MASK & ~longint'(63);
  endfunction

  function automatic bit m_offer_v(bit dm, bit rst);
    return !rst && !dm && m_phase == 2 && line_of(m_cur) != m_last_line;
  endfunction

  task automatic model_step(input bit rst, input bit init, input bit tv, input longint pc,
                            input longint addr, input logic [7:0] st, input bit fl,
                            input bit dm, input bit y);
    bit nonempty, popping, adv, iss, do_push;
    int next;
    longint s;
    cand_t nc, c;
    if (rst) begin
      m_q.delete(); m_phase = 0; m_cur = 0; m_stride = 0; m_left = 0;
      m_last_line = 0; m_last_pc = 0; m_issued = 0; m_dropped = 0; m_skipped = 0;
      return;
    end
    nonempty = m_q.size() > 0;
    popping  = (m_phase == 1);
    adv = 0; iss = 0; do_push = 0;
    if (m_phase == 2 && !dm) begin
      if (line_of(m_cur) == m_last_line) begin adv = 1; m_skipped++; end
      else if (y) begin adv = 1; iss = 1; m_issued++; end
    end
    if (tv && init && !fl) begin
      s = longint'($signed(st));
      if (s == 0 || (m_q.size() == QD && !popping) || (pc == m_last_pc && nonempty))
        m_dropped++;
      else begin
        do_push = 1; nc.addr = (addr + s) & MASK; nc.stride = s; m_last_pc = pc;
      end
    end
    next = m_phase;
    if (m_phase == 0) begin
      if (nonempty) next = 1;
    end else if (m_phase == 1) begin
      c = m_q.pop_front(); m_cur = c.addr; m_stride = c.stride; m_left = DEG; next = 2;
    end else if (adv) begin
      if (iss) m_last_line = line_of(m_cur);
      m_cur = (m_cur + m_stride) & MASK;
      m_left--;
      if (m_left == 0) next = nonempty ? 1 : 0;
    end
    if (do_push) m_q.push_back(nc);
    if (fl) begin m_q.delete(); next = 0; m_last_pc = 0; end
    m_phase = next;
  endtask

  // ---------------- checking ----------------
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic compare(input bit ev);
    chk("pf_v", 64'(pf_if.pf_v), 64'(ev));
    if (ev) chk("pf_addr", 64'(pf_if.pf_addr), line_of(m_cur));
    chk("busy", 64'(busy_o), 64'(m_phase != 0 || m_q.size() > 0));
`ifdef BP_BE_RPT_PF_STATS_EN
    chk("stat_issued",  64'(stats_o[31:0]),  64'(m_issued));
    chk("stat_dropped", 64'(stats_o[63:32]), 64'(m_dropped));
    chk("stat_skipped", 64'(stats_o[95:64]), 64'(m_skipped));
`endif
  endtask

  // One clock: drive at negedge, compare mid-cycle, advance the model
  task automatic tick(input bit rst, input bit tv, input longint pc, input longint addr,
                      input logic [7:0] st, input bit fl);
    bit ev, y;
    @(negedge clk);
    reset_i = rst; init_done_i = g_init; train_v_i = tv;
    train_pc_i = pc[38:0]; train_addr_i = addr[38:0]; train_stride_i = st;
    flush_i = fl; demand_v_i = g_demand;
    ev = m_offer_v(g_demand, rst);
    y  = ev && g_yumi;
    pf_if.pf_yumi = y;
    #1;
    if (g_cmp) compare(ev);
    if (pf_if.pf_v && y) begin
      got.push_back(longint'(pf_if.pf_addr));
      $display("issue addr=%h t=%0t", pf_if.pf_addr, $time);
    end
    model_step(rst, g_init, tv, pc, addr, st, fl, g_demand, y);
  endtask

  task automatic idle(input int n);
    repeat (n) tick(0, 0, 0, 0, 8'h00, 0);
  endtask

  task automatic train(input longint pc, input longint addr, input logic [7:0] st);
    tick(0, 1, pc, addr, st, 0);
  endtask

  initial begin
    logic [7:0] st;
    reset_i = 1; init_done_i = 0; train_v_i = 0; flush_i = 0; demand_v_i = 0;
    train_pc_i = '0; train_addr_i = '0; train_stride_i = '0; pf_if.pf_yumi = 0;
    g_cmp = 0; g_yumi = 0; g_demand = 0; g_init = 0;
    model_step(1, 0, 0, 0, 0, 8'h00, 0, 0, 0);
    tick(1, 0, 0, 0, 8'h00, 0);
    tick(1, 0, 0, 0, 8'h00, 0);
    @(posedge clk); #1;
    chk("reset_pf_v", 64'(pf_if.pf_v), 64'd0);
    chk("reset_pf_addr", 64'(pf_if.pf_addr), 64'd0);
    chk("reset_busy", 64'(busy_o), 64'd0);
    g_cmp = 1; g_init = 1; g_yumi = 1;

    // Basic expansion of one candidate
    got.delete();
    train('h100, 'h8000, 8'd64);
    idle(8);
    chk("basic_count", 64'(got.size()), 64'd2);
    if (got.size() == 2) begin
      chk("basic_addr0", got[0], 64'h8040);
      chk("basic_addr1", got[1], 64'h8080);
    end
    chk("basic_busy", 64'(busy_o), 64'd0);

    // Same-line second step is skipped
    got.delete();
    train('h200, 'h8000, 8'd8);
    idle(8);
    chk("sameline_count", 64'(got.size()), 64'd1);
    if (got.size() >= 1) chk("sameline_addr", got[0], 64'h8000);
`ifdef BP_BE_RPT_PF_STATS_EN
    chk("sameline_stat", 64'(stats_o[95:64]), 64'd1);
`endif

    // Negative stride wrapping below zero
    got.delete();
    train('h300, 'h0, 8'hC0);
    idle(8);
    chk("wrap_count", 64'(got.size()), 64'd2);
    if (got.size() == 2) begin
      chk("wrap_addr0", got[0], 64'h7F_FFFF_FFC0);
      chk("wrap_addr1", got[1], 64'h7F_FFFF_FF80);
    end

    // Demand contention holds the offer without losing it
    got.delete();
    train('h400, 'h10000, 8'd64);
    idle(2);
    g_demand = 1;
    for (int i = 0; i < 3; i++) begin
      idle(1);
      chk("demand_pf_v", 64'(pf_if.pf_v), 64'd0);
    end
    g_demand = 0;
    idle(6);
    chk("demand_count", 64'(got.size()), 64'd2);
    if (got.size() == 2) chk("demand_addr0", got[0], 64'h10040);

    // Queue full: six back-to-back trainings, one dropped
    got.delete();
    g_yumi = 0;
    for (int i = 0; i < 6; i++) train('h500 + 4*i, 'h20000 + 'h1000*i, 8'd64);
    chk("model_full_drop", 64'(m_dropped), 64'd1);
    idle(3);
    g_yumi = 1;
    idle(40);
    chk("full_count", 64'(got.size()), 64'd10);

    // Repeated PC back-to-back is dropped
    got.delete();
    train('h600, 'h30000, 8'd64);
    train('h600, 'h40000, 8'd64);
    idle(10);
    chk("dup_count", 64'(got.size()), 64'd2);
    if (got.size() == 2) chk("dup_addr1", got[1], 64'h30080);

    // Flush with three queued and an offer pending; training alongside ignored
    got.delete();
    g_yumi = 0;
    for (int i = 0; i < 4; i++) train('h700 + 4*i, 'h50000 + 'h1000*i, 8'd64);
    idle(1);
    tick(0, 1, 'h800, 'h60000, 8'd64, 1);
    idle(1);
    chk("flush_pf_v", 64'(pf_if.pf_v), 64'd0);
    chk("flush_busy", 64'(busy_o), 64'd0);
    g_yumi = 1;
    idle(10);
    chk("flush_count", 64'(got.size()), 64'd0);

    // Randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      g_demand = ($urandom_range(0, 3) == 0);
      g_yumi   = ($urandom_range(0, 9) < 6);
      g_init   = ($urandom_range(0, 19) != 0);
      case ($urandom_range(0, 5))
        0: st = 8'd0;
        1: st = 8'd8;
        2: st = 8'd64;
        3: st = 8'hC0;
        4: st = 8'h80;
        default: st = 8'($urandom);
      endcase
      tick(($urandom_range(0, 199) == 0), ($urandom_range(0, 9) < 3),
           longint'('h100 + 4*$urandom_range(0, 4)),
           longint'({$urandom, $urandom}) & MASK, st,
           ($urandom_range(0, 49) == 0));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
